// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and helpers for the two-port block-RAM arbiter.
package bram_port_arbiter_pkg;

  // Number of bits needed to represent value (0 for value == 0).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  typedef enum logic {
    StClear,
    StRun
  } state_e;

  typedef logic port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t id;
  } pipe_entry_t;

endpackage

// File: rtl/bram_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves only when a grant is issued.
module rr_arb2
  import bram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  port_id_t last_q;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // On a tie favour the port that was not served last.
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (|grant) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port read-first block RAM between two requesters, with an
// optional zero-fill after reset and a fixed-latency response pipeline.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned LATENCY        = 1,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned AW = (clogb2(DEPTH - 1) > 1) ? clogb2(DEPTH - 1) : 1
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [AW-1:0]     req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [AW-1:0]     req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              clear_done,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [AW-1:0]     ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic              ram_rsta,
  output logic              ram_regcea,
  input  logic [DATA_W-1:0] ram_douta
);

  localparam state_e        ResetState = (CLEAR_ON_RESET != 0) ? StClear : StRun;
  localparam logic [AW-1:0] LastAddr   = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [AW-1:0] addr_hold_q;
  logic [DATA_W-1:0] din_hold_q;
  pipe_entry_t   pipe_q [LATENCY];
  pipe_entry_t   head;

  logic       running, clearing, accept;
  port_id_t   sel;
  logic [1:0] grant;

  // Gate with the reset input so nothing is issued while reset is held.
  assign running  = rsta_n && (state_q == StRun);
  assign clearing = rsta_n && (state_q == StClear);

  rr_arb2 u_arb (
    .clk   (clka),
    .rst_n (rsta_n),
    .en    (running),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign sel        = grant[1];

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == StClear) begin
      if (clr_addr_q == LastAddr) begin
        state_d = StRun;
      end else begin
        clr_addr_d = clr_addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q    <= ResetState;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Address and data hold their last driven value when the RAM is idle.
  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = addr_hold_q;
    ram_dina  = din_hold_q;
    if (clearing) begin
      ram_ena   = 1'b1;
      ram_wea   = 1'b1;
      ram_addra = clr_addr_q;
      ram_dina  = '0;
    end else if (accept) begin
      ram_ena   = 1'b1;
      ram_wea   = sel ? req1_we    : req0_we;
      ram_addra = sel ? req1_addr  : req0_addr;
      ram_dina  = sel ? req1_wdata : req0_wdata;
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      addr_hold_q <= '0;
      din_hold_q  <= '0;
    end else if (ram_ena) begin
      addr_hold_q <= ram_addra;
      din_hold_q  <= ram_dina;
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= pipe_entry_t'{valid: accept, id: sel};
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign head        = pipe_q[LATENCY-1];
  assign resp0_valid = head.valid && (head.id == 1'b0);
  assign resp1_valid = head.valid && (head.id == 1'b1);
  assign resp0_rdata = ram_douta;
  assign resp1_rdata = ram_douta;

  assign clear_done = running;
  assign ram_rsta   = (state_q == StClear);
  assign ram_regcea = 1'b1;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Drives two arbiter instances (read latency 1 and 2) with the same stimulus and
// checks both against a transaction-level model of the shared RAM.
module tb_bram_port_arbiter;

  localparam int Depth = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [3:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;

  logic [1:0]  rdy0, rdy1, rv0, rv1, ena, wea, rsta, regce, cdone;
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic [31:0] dina [2];
  logic [31:0] douta [2];
  logic [3:0]  addra [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [Depth];
    logic [31:0] q_raw, q_reg;

    bram_port_arbiter #(
      .DATA_W        (32),
      .DEPTH         (Depth),
      .LATENCY       (g + 1),
      .CLEAR_ON_RESET(1)
    ) u_dut (
      .clka       (clk),
      .rsta_n     (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (rdy0[g]),
      .req0_we    (req0_we),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req1_valid (req1_valid),
      .req1_ready (rdy1[g]),
      .req1_we    (req1_we),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .resp0_valid(rv0[g]),
      .resp0_rdata(rd0[g]),
      .resp1_valid(rv1[g]),
      .resp1_rdata(rd1[g]),
      .clear_done (cdone[g]),
      .ram_ena    (ena[g]),
      .ram_wea    (wea[g]),
      .ram_addra  (addra[g]),
      .ram_dina   (dina[g]),
      .ram_rsta   (rsta[g]),
      .ram_regcea (regce[g]),
      .ram_douta  (douta[g])
    );

    // Read-first single-port RAM with optional output register.
    always @(posedge clk) begin
      if (ena[g]) begin
        q_raw <= mem[addra[g]];
        if (wea[g]) mem[addra[g]] <= dina[g];
      end
      if (rsta[g]) q_reg <= '0;
      else if (regce[g]) q_reg <= q_raw;
    end
    assign douta[g] = (g == 0) ? q_raw : q_reg;
  end

  // Reference model: memory contents, last-served port and expected responses
  // scheduled by cycle slot for each latency.
  logic [31:0] mmem [Depth];
  bit          mlast;
  int          cyc;
  bit          sv [2][4];
  bit          sid [2][4];
  logic [31:0] sd [2][4];
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v0, input bit w0, input int a0, input logic [31:0] d0,
                       input bit v1, input bit w1, input int a1, input logic [31:0] d1);
    req0_valid = v0; req0_we = w0; req0_addr = 4'(a0); req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = 4'(a1); req1_wdata = d1;
  endtask

  task automatic rand_req();
    drive(bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)), $urandom_range(Depth - 1, 0),
          $urandom, bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)),
          $urandom_range(Depth - 1, 0), $urandom);
  endtask

  // One cycle: check this cycle's outputs, advance the model, move to next cycle.
  task automatic step();
    bit run, g0, g1, we;
    int s, slot;
    logic [3:0]  a;
    logic [31:0] wd;
    #1;
    run = (cyc >= Depth);
    g0  = run && req0_valid && (!req1_valid || mlast);
    g1  = run && req1_valid && (!req0_valid || !mlast);
    a   = g1 ? req1_addr  : req0_addr;
    we  = g1 ? req1_we    : req0_we;
    wd  = g1 ? req1_wdata : req0_wdata;
    s   = cyc % 4;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready0[%0d]@%0d", k, cyc), 32'(rdy0[k]), 32'(g0));
      chk($sformatf("ready1[%0d]@%0d", k, cyc), 32'(rdy1[k]), 32'(g1));
      chk($sformatf("clear_done[%0d]@%0d", k, cyc), 32'(cdone[k]), 32'(run));
      chk($sformatf("ram_rsta[%0d]@%0d", k, cyc), 32'(rsta[k]), 32'(!run));
      chk($sformatf("regcea[%0d]@%0d", k, cyc), 32'(regce[k]), 32'd1);
      chk($sformatf("resp0_valid[%0d]@%0d", k, cyc), 32'(rv0[k]), 32'(sv[k][s] && !sid[k][s]));
      chk($sformatf("resp1_valid[%0d]@%0d", k, cyc), 32'(rv1[k]), 32'(sv[k][s] && sid[k][s]));
      if (sv[k][s])
        chk($sformatf("rdata[%0d]@%0d", k, cyc), sid[k][s] ? rd1[k] : rd0[k], sd[k][s]);
      sv[k][s] = 1'b0;
      if (!run) begin
        chk($sformatf("clr_ena[%0d]@%0d", k, cyc), 32'(ena[k] & wea[k]), 32'd1);
        chk($sformatf("clr_addr[%0d]@%0d", k, cyc), 32'(addra[k]), 32'(cyc % Depth));
        chk($sformatf("clr_din[%0d]@%0d", k, cyc), dina[k], 32'd0);
      end else if (g0 || g1) begin
        chk($sformatf("iss_ena[%0d]@%0d", k, cyc), 32'(ena[k]), 32'd1);
        chk($sformatf("iss_we[%0d]@%0d", k, cyc), 32'(wea[k]), 32'(we));
        chk($sformatf("iss_addr[%0d]@%0d", k, cyc), 32'(addra[k]), 32'(a));
        if (we) chk($sformatf("iss_din[%0d]@%0d", k, cyc), dina[k], wd);
      end else begin
        chk($sformatf("idle_ena[%0d]@%0d", k, cyc), 32'(ena[k] | wea[k]), 32'd0);
      end
    end
    if (g0 || g1) begin
      for (int k = 0; k < 2; k++) begin
        slot = (cyc + k + 1) % 4;
        sv[k][slot]  = 1'b1;
        sid[k][slot] = g1;
        sd[k][slot]  = mmem[a];
      end
      if (we) mmem[a] = wd;
      mlast = g1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Assert reset (drops in-flight responses), hold with requests pending, release.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1, 0, 1, 0, 1, 1, 2, 32'h5);
    mlast = 1'b1;
    for (int i = 0; i < Depth; i++) mmem[i] = '0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 4; j++) sv[k][j] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rst_resp[%0d]", k), 32'({rv0[k], rv1[k]}), 32'd0);
        chk($sformatf("rst_ready[%0d]", k), 32'({rdy0[k], rdy1[k]}), 32'd0);
        chk($sformatf("rst_ena[%0d]", k), 32'({ena[k], wea[k]}), 32'd0);
        chk($sformatf("rst_done[%0d]", k), 32'(cdone[k]), 32'd0);
        chk($sformatf("rst_rsta[%0d]", k), 32'(rsta[k]), 32'd1);
        chk($sformatf("rst_addr[%0d]", k), 32'(addra[k]), 32'd0);
        chk($sformatf("rst_din[%0d]", k), dina[k], 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    do_reset();
    for (int i = 0; i < Depth; i++) begin rand_req(); step(); end

    drive(1, 1, 5, 32'hA5, 0, 0, 0, 0); step();
    drive(1, 1, 5, 32'h11, 0, 0, 0, 0); step();
    drive(1, 0, 5, 0, 0, 0, 0, 0);      step();
    drive(0, 0, 0, 0, 1, 1, 3, 32'h33); step();
    drive(0, 0, 0, 0, 1, 1, 4, 32'h44); step();
    for (int i = 0; i < 8; i++) begin drive(1, 0, 3, 0, 1, 0, 4, 0); step(); end
    drive(0, 0, 0, 0, 1, 1, 9, 32'hDEAD); step();
    drive(1, 0, 9, 0, 0, 0, 0, 0);        step();
    for (int i = 0; i < 8; i++) begin drive(1, 0, i, 0, 0, 0, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0); step(); step();
    for (int i = 0; i < 400; i++) begin rand_req(); step(); end

    drive(1, 0, 2, 0, 0, 0, 0, 0); step(); step();
    do_reset();
    for (int i = 0; i < Depth; i++) begin rand_req(); step(); end
    for (int i = 0; i < 60; i++) begin rand_req(); step(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0); step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares one single-port read-first block RAM between two requesters (port 0, port 1) with per-port valid/ready request handshakes and fixed-latency responses. Optionally zero-fills the RAM after reset, then runs a round-robin arbiter issuing at most one RAM operation per cycle. Sits between the RAM instance and its clients, such as a fetch-side reader and a write-capable side.

## Interface
- `DATA_W`, 32, data width of the RAM word.
- `DEPTH`, 1024, number of RAM entries; `AW = clogb2(DEPTH-1)` with a minimum of 1.
- `LATENCY`, 1, RAM read latency in cycles: 1 = no output register, 2 = output register.
- `CLEAR_ON_RESET`, 1, when 1 the RAM is zero-filled after reset before requests are accepted.
- `clka`  in  1  clock.
- `rsta_n`  in  1  reset; **asynchronous, active-low**.
- `reqN_valid`  in  1  port N request valid (N = 0, 1).
- `reqN_ready`  out  1  port N request accepted this cycle.
- `reqN_we`  in  1  port N write (1) or read (0).
- `reqN_addr`  in  AW  port N address.
- `reqN_wdata`  in  DATA_W  port N write data.
- `respN_valid`  out  1  port N response valid, one cycle.
- `respN_rdata`  out  DATA_W  port N read data (for writes, the prior contents).
- `clear_done`  out  1  high once the controller is in RUN.
- `ram_ena`, `ram_wea`  out  1  RAM enable and write enable.
- `ram_addra`  out  AW  RAM address.
- `ram_dina`  out  DATA_W  RAM write data.
- `ram_rsta`  out  1  RAM output-register reset, active-high.
- `ram_regcea`  out  1  RAM output-register enable, tied to 1.
- `ram_douta`  in  DATA_W  RAM read data.

## Operation
- **States.**
  - CLEAR is entered on reset when `CLEAR_ON_RESET=1`; otherwise reset enters RUN directly.
  - In CLEAR, a counter `clr_addr` runs 0..DEPTH-1 with `ram_ena=1`, `ram_wea=1`, `ram_dina=0` every cycle.
  - At `clr_addr==DEPTH-1` the state moves CLEAR→RUN on that edge. The counter never wraps, and non-power-of-two DEPTH stops at DEPTH-1.
- **CLEAR outputs.** `ram_rsta=1`, both `reqN_ready=0`, and no responses are produced.
- **RUN arbitration.**
  - Grant goes to the only valid port. If both are valid, grant goes to the port not granted last.
  - The `last` pointer updates only on an accepted transfer. It resets to 1, so port 0 wins the first tie.
  - `reqN_ready` is 1 only for the granted port in RUN. It is combinational from `valid`/state; `valid` must not depend on `ready`.
- **Issue.** When a transfer is accepted: `ram_ena=1`, `ram_wea=reqN_we`, `ram_addra=reqN_addr`, `ram_dina=reqN_wdata`. Otherwise `ram_ena=0`, `ram_wea=0`, and the address/data outputs hold their previous values.
- **Response pipeline.**
  - A `LATENCY`-deep shift register carries {valid, id} for each issued operation.
  - At the head: `respN_valid = head.valid && head.id==N`, and `respN_rdata = ram_douta`, broadcast to both ports.
  - Every accepted operation, read or write, yields exactly one response.
  - There is no response backpressure; clients must accept responses.
- **Read-first.** A write's response carries the old word. A read issued in the cycle after a write to the same address returns the new word.
- **Reset mid-operation.** Asynchronous assertion clears the pipeline, state, pointer and counter immediately; in-flight responses are dropped. Deassertion restarts CLEAR from address 0.
- **Reset values.** All `reqN_ready`, `respN_valid`, `ram_ena`, `ram_wea` and `clear_done` are 0. `ram_addra` and `ram_dina` are 0. `ram_rsta` is 1 if `CLEAR_ON_RESET`, else 0.

## Timing
- **Accept.** Accepted in cycle T (`valid && ready` sampled at edge T) → response in cycle T+LATENCY.
- **Throughput.** One operation per cycle total across both ports.
- **Sole requester.** A single active port can issue back-to-back every cycle.
- **Fairness.** Under continuous contention, grants alternate 0,1,0,1…
- **CLEAR duration.** Exactly DEPTH cycles after reset deassertion; `clear_done` rises the cycle after the last clear write.
- **First request.** The first request can be accepted in the same cycle `clear_done` is high.

## Structure
- **Shared package:** `clogb2` function, state enum {CLEAR, RUN}, port-id type (1 bit), response-pipe entry struct {valid, id}.
- **Sub-module:** `rr_arb2`, a two-input round-robin arbiter (valid in, grant out, pointer update on accept). Pipeline, clear counter and muxing stay in the top.

## Test plan
- **Clear:** DEPTH=16, `CLEAR_ON_RESET=1` → 16 writes of 0 to addresses 0..15; `clear_done` first high in cycle 16 after deassertion; no `ready` before that.
- **Read-first write:** pre-load addr 5=0xA5; port 0 writes 0x11 to addr 5 → `resp0_rdata=0xA5` after LATENCY cycles; next read of addr 5 → 0x11.
- **Contention:** both ports reading continuously, addr0=3 (holding 0x33), addr1=4 (holding 0x44) → grant order 0,1,0,1; responses alternate 0x33 to port 0 and 0x44 to port 1; `resp1_valid` never high in a port-0 response cycle.
- **Latency:** run with LATENCY=1 and LATENCY=2 → response exactly 1 and 2 cycles after accept; back-to-back reads of addresses 0..7 return in order.
- **Reset mid-operation:** assert `rsta_n=0` with 2 reads in flight → no `respN_valid` appears; after release, CLEAR restarts at address 0.
- **Write/read chaining:** port 1 writes 0xDEAD to addr 9 in cycle T, port 0 reads addr 9 in cycle T+1 → port 0 gets 0xDEAD.
